// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, MMIO map and line-status bit positions
package uart_pkg;

  // Drain sequencer states for the transmit buffer
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // MMIO addresses decoded by the core write/read paths
  localparam logic [31:0] UART_RW_ADDRESS     = 32'h1001_0000;
  localparam logic [31:0] UART_STATUS_ADDRESS = 32'h1001_0005;
  localparam logic [31:0] BAUD_MAX_ADDRESS    = 32'h1001_0100;

  // Line-status register bit positions
  localparam int LSR_READ_READY  = 0;
  localparam int LSR_TX_OVERFLOW = 4;
  localparam int LSR_TX_FULL     = 5;
  localparam int LSR_BUSY        = 6;

  // Assembles the line-status byte; busy should be driven with !empty || uart_busy
  function automatic logic [7:0] line_status(
    input logic read_ready,
    input logic busy,
    input logic tx_full,
    input logic tx_overflow
  );
    logic [7:0] lsr;
    lsr                  = 8'h00;
    lsr[LSR_READ_READY]  = read_ready;
    lsr[LSR_TX_OVERFLOW] = tx_overflow;
    lsr[LSR_TX_FULL]     = tx_full;
    lsr[LSR_BUSY]        = busy;
    return lsr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular FIFO with registered occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  // A push while full is dropped even if a pop frees a slot this cycle
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign level    = count;

  // Storage array; reset discards contents by rewinding the pointers only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit buffer draining queued bytes into the UART one frame at a time
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   clr_overflow,
  input  logic                   uart_busy,
  output logic [7:0]             uart_data,
  output logic                   uart_write_enable,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              pop;
  logic [7:0]        pop_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Sticky drop flag; a dropped push in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Drain sequencer registers; the strobe is registered so it is high exactly while in ISSUE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      uart_data         <= 8'h00;
      uart_write_enable <= 1'b0;
    end else begin
      state             <= state_next;
      wait_cnt          <= wait_next;
      uart_write_enable <= (state_next == ISSUE);
      if (pop) begin
        uart_data <= pop_data;
      end
    end
  end

  // Next-state logic; a UART that never acknowledges is abandoned after BUSY_WAIT_MAX cycles
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_busy) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wait_next  = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_next = WAIT_DONE;
        end else begin
          wait_next = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer between the core's MMIO write path and the UART transmitter. Accepts bytes written to the UART data address at one per cycle, stores them in a circular FIFO, and feeds them to the UART one at a time, waiting for each transmission to finish before issuing the next. The core can stream several bytes without polling the UART busy flag per byte. Its status bits feed the UART line-status register.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2
- BUSY_WAIT_MAX, 4: cycles to wait for uart_busy to rise after an issue before giving up

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- push  in  1  core write strobe (write_enable && address == UART_RW_ADDRESS)
- push_data  in  8  byte to enqueue (write_data[7:0])
- clr_overflow  in  1  clears the sticky overflow flag
- uart_busy  in  1  UART transmitter busy
- uart_data  out  8  byte presented to the UART, registered
- uart_write_enable  out  1  one-cycle issue strobe to the UART, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; set when a push is dropped
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: wr_ptr/rd_ptr, $clog2(DEPTH) bits each, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Push: accepted iff !full at the start of the cycle. Data is written at wr_ptr and wr_ptr is incremented. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Push and pop in the same cycle with the FIFO not full: both take effect and count is unchanged.
- overflow: set by a dropped push, cleared by clr_overflow. If both happen in the same cycle, set wins.
- Drain FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty && !uart_busy, then uart_data <= mem[rd_ptr], pop (rd_ptr++), and go to ISSUE.
  - ISSUE: uart_write_enable = 1 for exactly this cycle; clear the wait counter; go to WAIT_BUSY.
  - WAIT_BUSY: if uart_busy, go to WAIT_DONE. Otherwise increment the wait counter; when it reaches BUSY_WAIT_MAX, go to IDLE (the byte counts as sent; there is no retry).
  - WAIT_DONE: when !uart_busy, go to IDLE.
- uart_data holds its value until the next pop.
- Reset (rst == 0 at a rising edge), including mid-transmission:
  - Pointers, count, overflow and wait counter go to 0; FSM goes to IDLE.
  - Outputs: uart_data = 8'h00, uart_write_enable = 0, full = 0, empty = 1, overflow = 0, level = 0.
  - A byte already handed to the UART is not recalled. Queued bytes are discarded.

## Timing
- full, empty and level are registered and reflect count after the previous edge.
- Push-to-issue latency: a push in cycle N into an empty FIFO with the UART idle gives uart_write_enable = 1 in cycle N+2.
- Back-to-back bytes: the next issue comes no earlier than 2 cycles after uart_busy falls (WAIT_DONE→IDLE, IDLE→ISSUE).
- Sustained push rate: 1/cycle until full. Drain rate is bounded by UART frame time.
- uart_write_enable is never high in two consecutive cycles.

## Structure
- Shared package `uart_pkg`:
  - tx_state_t enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE)
  - MMIO constants: UART_RW_ADDRESS = 32'h10010000, UART_STATUS_ADDRESS = 32'h10010005, BAUD_MAX_ADDRESS = 32'h10010100
  - Line-status bit indices: bit 0 read_ready, bit 6 busy, new bit 5 tx_full, new bit 4 tx_overflow
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) holds storage, pointers, count, full and empty. uart_tx_fifo wraps it with the drain FSM, the overflow flag and the UART handshake.
- Top-level integration:
  - The UART takes uart_data / uart_write_enable in place of tx_holding / uart_write_enable.
  - The line-status "busy" bit becomes !empty || uart_busy.

## Test plan
- Reset mid-transmission: hold rst = 0 during WAIT_DONE with 3 bytes queued -> after release, empty = 1, level = 0, state IDLE, no uart_write_enable until a new push.
- Single byte: push 8'h41 with the UART idle and the model raising busy one cycle after the strobe for 10 cycles -> uart_write_enable high only in cycle N+2 with uart_data = 8'h41, then empty = 1.
- Burst: push 8'h10..8'h14 on consecutive cycles -> level peaks at 4 (one already popped), bytes issued in order, each strobe only after busy falls, never two strobes in a row.
- Overflow: with uart_busy held high, push DEPTH+2 bytes -> full = 1, level = DEPTH, overflow = 1, last two bytes absent from the drained stream; clr_overflow then clears overflow.
- Busy never rises: the UART model ignores the strobe -> FSM returns to IDLE after BUSY_WAIT_MAX cycles and issues the next queued byte.
- Simultaneous push/pop at level 1: a push in the same cycle as IDLE→ISSUE -> level stays 1 and both bytes are issued in order.
